// File: rtl/matrix_alu_seq.sv
// Sequential N x N matrix ALU: register-file operands A, B, scalar c and result G,
// one element step (or one multiply-accumulate) per clock under a start/done handshake.
module matrix_alu_seq #(
   parameter int unsigned N  = 3,
   parameter int unsigned DW = 32,
   parameter int unsigned IW = $clog2(N*N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en_i,
   input  logic [1:0]    wr_sel_i,
   input  logic [IW-1:0] wr_idx_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic          start_i,
   input  logic [2:0]    op_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   input  logic [IW-1:0] rd_idx_i,
   output logic [DW-1:0] rd_data_o,
   output logic [DW-1:0] s_out_o
);

   localparam int unsigned NN = N * N;
   localparam int unsigned CW = $clog2(N);

   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   localparam logic [2:0] OP_TRN = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_MUL = 3'd3;
   localparam logic [2:0] OP_SCL = 3'd4;
   localparam logic [2:0] OP_TRC = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] a_q [NN];
   logic [DW-1:0] b_q [NN];
   logic [DW-1:0] g_q [NN];
   logic [DW-1:0] c_q, acc_q, s_q, rd_q;
   logic [CW-1:0] i_q, j_q, k_q;
   logic [2:0]    op_q;
   logic          err_q, busy_q, done_q;

   logic          last_c;
   logic [IW-1:0] e_c;
   logic [DW-1:0] prod_c, elem_c, diag_c;

   function automatic logic [IW-1:0] flat(input logic [CW-1:0] r, input logic [CW-1:0] col);
      return IW'(r) * IW'(N) + IW'(col);
   endfunction

   function automatic logic idx_ok(input logic [IW-1:0] idx);
      return 32'(idx) < NN;
   endfunction

   // Element-step datapath and end-of-operation detection
   always_comb begin
      e_c    = flat(i_q, j_q);
      prod_c = a_q[flat(i_q, k_q)] * b_q[flat(k_q, j_q)];
      diag_c = a_q[flat(k_q, k_q)];
      elem_c = '0;
      last_c = 1'b1;
      case (op_q)
         OP_TRN: elem_c = a_q[flat(j_q, i_q)];
         OP_ADD: elem_c = a_q[e_c] + b_q[e_c];
         OP_SUB: elem_c = a_q[e_c] - b_q[e_c];
         OP_SCL: elem_c = c_q * a_q[e_c];
         default: elem_c = '0;
      endcase
      case (op_q)
         OP_TRN, OP_ADD, OP_SUB, OP_SCL: last_c = (i_q == LAST) && (j_q == LAST);
         OP_MUL: last_c = (i_q == LAST) && (j_q == LAST) && (k_q == LAST);
         OP_TRC: last_c = (k_q == LAST);
         default: last_c = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = S_RUN;
         S_RUN:   if (last_c)  state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == S_RUN);
         done_q  <= (state_d == S_FIN);
      end
   end

   // Operand/result storage, counters and read port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned x = 0; x < NN; x++) begin
            a_q[x] <= '0;
            b_q[x] <= '0;
            g_q[x] <= '0;
         end
         c_q   <= '0;
         acc_q <= '0;
         s_q   <= '0;
         rd_q  <= '0;
         i_q   <= '0;
         j_q   <= '0;
         k_q   <= '0;
         op_q  <= '0;
         err_q <= 1'b0;
      end else begin
         rd_q <= idx_ok(rd_idx_i) ? g_q[rd_idx_i] : '0;
         if (state_q == S_IDLE) begin
            if (wr_en_i) begin
               case (wr_sel_i)
                  2'd0:    if (idx_ok(wr_idx_i)) a_q[wr_idx_i] <= wr_data_i;
                  2'd1:    if (idx_ok(wr_idx_i)) b_q[wr_idx_i] <= wr_data_i;
                  2'd2:    c_q <= wr_data_i;
                  default: ;
               endcase
            end
            if (start_i) begin
               op_q  <= op_i;
               err_q <= (op_i > OP_TRC);
               i_q   <= '0;
               j_q   <= '0;
               k_q   <= '0;
               acc_q <= '0;
            end
         end else if (state_q == S_RUN) begin
            case (op_q)
               OP_TRN, OP_ADD, OP_SUB, OP_SCL: begin
                  g_q[e_c] <= elem_c;
                  if (j_q == LAST) begin
                     j_q <= '0;
                     i_q <= i_q + ONE;
                  end else begin
                     j_q <= j_q + ONE;
                  end
               end
               OP_MUL: begin
                  if (k_q == LAST) begin
                     g_q[e_c] <= acc_q + prod_c;
                     acc_q    <= '0;
                     k_q      <= '0;
                     if (j_q == LAST) begin
                        j_q <= '0;
                        i_q <= i_q + ONE;
                     end else begin
                        j_q <= j_q + ONE;
                     end
                  end else begin
                     acc_q <= acc_q + prod_c;
                     k_q   <= k_q + ONE;
                  end
               end
               OP_TRC: begin
                  acc_q <= acc_q + diag_c;
                  k_q   <= k_q + ONE;
                  if (k_q == LAST) s_q <= acc_q + diag_c;
               end
               default: ;
            endcase
         end
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign err_o     = err_q;
   assign rd_data_o = rd_q;
   assign s_out_o   = s_q;

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Scoreboard bench for matrix_alu_seq: stimulus pushes expected results from a
// plain-arithmetic matrix model; a monitor pops and checks on every done pulse.
module tb_matrix_alu_seq;

   localparam int unsigned N  = 3;
   localparam int unsigned DW = 32;
   localparam int unsigned IW = 4;
   localparam int unsigned NN = N * N;

   typedef struct packed {
      logic [NN-1:0][DW-1:0] g;
      logic [DW-1:0]         s;
      logic                  err;
      logic [7:0]            lat;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_en = 1'b0;
   logic [1:0]    wr_sel = 2'd3;
   logic [IW-1:0] wr_idx = '0;
   logic [DW-1:0] wr_data = '0;
   logic          start = 1'b0;
   logic [2:0]    op_in = 3'd0;
   logic          busy_o, done_o, err_o;
   logic [IW-1:0] rd_idx = '0;
   logic [DW-1:0] rd_data_o, s_out_o;

   exp_t          sb[$];
   logic [DW-1:0] ma[NN], mb[NN], mg[NN];
   logic [DW-1:0] mc, ms;
   int            checks = 0;
   int            passed = 0;
   int            rb_count = 0;
   int            exp_done = 0;
   int            mon_bcnt = 0;

   always #5 clk = ~clk;

   matrix_alu_seq #(.N(N), .DW(DW), .IW(IW)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_en),
      .wr_sel_i  (wr_sel),
      .wr_idx_i  (wr_idx),
      .wr_data_i (wr_data),
      .start_i   (start),
      .op_i      (op_in),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .err_o     (err_o),
      .rd_idx_i  (rd_idx),
      .rd_data_o (rd_data_o),
      .s_out_o   (s_out_o)
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
   endtask

   task automatic model_clear();
      for (int x = 0; x < NN; x++) begin
         ma[x] = '0; mb[x] = '0; mg[x] = '0;
      end
      mc = '0;
      ms = '0;
   endtask

   task automatic mwrite(input logic [1:0] sel, input int idx, input logic [DW-1:0] d);
      if (sel == 2'd0 && idx < NN) ma[idx] = d;
      if (sel == 2'd1 && idx < NN) mb[idx] = d;
      if (sel == 2'd2) mc = d;
   endtask

   // Reference matrix semantics, written as textbook loops
   task automatic model(input logic [2:0] op, output exp_t e);
      logic [DW-1:0] sum;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            case (op)
               3'd0: mg[i*N+j] = ma[j*N+i];
               3'd1: mg[i*N+j] = ma[i*N+j] + mb[i*N+j];
               3'd2: mg[i*N+j] = ma[i*N+j] - mb[i*N+j];
               3'd3: begin
                  sum = '0;
                  for (int k = 0; k < N; k++) sum = sum + ma[i*N+k] * mb[k*N+j];
                  mg[i*N+j] = sum;
               end
               3'd4: mg[i*N+j] = mc * ma[i*N+j];
               default: ;
            endcase
         end
      if (op == 3'd5) begin
         sum = '0;
         for (int k = 0; k < N; k++) sum = sum + ma[k*N+k];
         ms = sum;
      end
      for (int x = 0; x < NN; x++) e.g[x] = mg[x];
      e.s   = ms;
      e.err = (op >= 3'd6);
      case (op)
         3'd3:    e.lat = 8'(N * N * N);
         3'd5:    e.lat = 8'(N);
         3'd6,
         3'd7:    e.lat = 8'd1;
         default: e.lat = 8'(N * N);
      endcase
   endtask

   task automatic wr(input logic [1:0] sel, input int idx, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_sel = sel; wr_idx = IW'(idx); wr_data = d;
      mwrite(sel, idx, d);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic go(input logic [2:0] op);
      exp_t e;
      model(op, e);
      sb.push_back(e);
      exp_done++;
      start = 1'b1; op_in = op;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic go_w(input logic [2:0] op, input logic [1:0] sel, input int idx, input logic [DW-1:0] d);
      exp_t e;
      wr_en = 1'b1; wr_sel = sel; wr_idx = IW'(idx); wr_data = d;
      mwrite(sel, idx, d);
      model(op, e);
      sb.push_back(e);
      exp_done++;
      start = 1'b1; op_in = op;
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int t = 0;
      while (rb_count < exp_done && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk({name, "_complete"}, DW'(rb_count), DW'(exp_done));
   endtask

   // Monitor: latency, err, s_out and full G readback on each done pulse
   initial begin
      exp_t          e;
      logic [DW-1:0] want;
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_bcnt = 0;
         end else begin
            if (busy_o) mon_bcnt++;
            if (done_o) begin
               if (sb.size() == 0) begin
                  chk("done_expected", DW'(sb.size()), 1);
               end else begin
                  e = sb.pop_front();
                  chk("err", DW'(err_o), DW'(e.err));
                  chk("s_out", s_out_o, e.s);
                  chk("busy_cycles", DW'(mon_bcnt), DW'(e.lat));
                  mon_bcnt = 0;
                  for (int x = 0; x <= NN; x++) begin
                     rd_idx = (x < NN) ? IW'(x) : IW'(15);
                     want = (x < NN) ? e.g[x] : '0;
                     @(negedge clk);
                     chk($sformatf("G[%0d]", x), rd_data_o, want);
                  end
                  rb_count++;
               end
            end
         end
      end
   end

   initial begin
      int nw;
      logic [1:0] sel;
      model_clear();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_busy", DW'(busy_o), 0);
      chk("rst_done", DW'(done_o), 0);
      chk("rst_err", DW'(err_o), 0);
      chk("rst_s_out", s_out_o, 0);
      chk("rst_rd_data", rd_data_o, 0);
      @(negedge clk);

      for (int x = 0; x < NN; x++) wr(2'd0, x, DW'(x + 1));
      for (int x = 0; x < NN; x++) wr(2'd1, x, DW'(9 - x));
      go(3'd1);
      wait_done("add");

      // MUL with an ignored start and an ignored write while busy
      go(3'd3);
      repeat (3) @(negedge clk);
      start = 1'b1; op_in = 3'd1;
      wr_en = 1'b1; wr_sel = 2'd0; wr_idx = '0; wr_data = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      wait_done("mul");

      go(3'd5);
      wait_done("trace");
      go(3'd0);
      wait_done("transpose");

      for (int x = 0; x < NN; x++) wr(2'd0, x, 0);
      for (int x = 0; x < NN; x++) wr(2'd1, x, 1);
      go(3'd2);
      wait_done("sub");
      wr(2'd2, 0, 32'h8000_0000);
      for (int x = 0; x < NN; x++) wr(2'd0, x, 2);
      go(3'd4);
      wait_done("scale");

      go(3'd7);
      wait_done("illegal");
      go(3'd1);
      wait_done("legal_after_illegal");

      // Reset ten cycles into a MUL
      for (int x = 0; x < NN; x++) wr(2'd0, x, DW'(x + 1));
      go(3'd5);
      wait_done("trace2");
      go(3'd3);
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      sb.delete();
      exp_done--;
      model_clear();
      chk("midrst_busy", DW'(busy_o), 0);
      chk("midrst_done", DW'(done_o), 0);
      chk("midrst_s_out", s_out_o, 0);
      chk("midrst_rd_data", rd_data_o, 0);
      chk("midrst_err", DW'(err_o), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      go(3'd5);
      wait_done("trace_after_reset");
      for (int x = 0; x < NN; x++) wr(2'd0, x, DW'(x + 1));
      for (int x = 0; x < NN; x++) wr(2'd1, x, DW'(9 - x));
      go(3'd1);
      wait_done("add_after_reset");

      // Randomised operand writes and operations
      for (int it = 0; it < 25; it++) begin
         nw = $urandom_range(0, 5);
         for (int w = 0; w < nw; w++) begin
            sel = 2'($urandom_range(0, 3));
            wr(sel, (sel == 2'd2) ? $urandom_range(0, 8) : $urandom_range(0, 15),
               ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(0, 20)));
         end
         if ($urandom_range(0, 2) == 0)
            go_w(3'($urandom_range(0, 7)), 2'($urandom_range(0, 1)), $urandom_range(0, 8), DW'($urandom));
         else
            go(3'($urandom_range(0, 7)));
         wait_done("random");
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
